// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped countdown timer.
// Covers register offsets, CTRL bit positions, mode codes and FSM state encodings.
package timer_counter_pkg;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_counter.sv
// Countdown timer with one-shot / auto-reload modes, driving one HWInt line of CP0.
// Programmed over the system bridge: CTRL, PRESET (r/w), COUNT (read-only).
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] PRESET_RST = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irq
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  state_t            state_reg, state_next;
  logic              en_reg, en_next;
  logic [1:0]        mode_reg, mode_next;
  logic              im_reg, im_next;
  logic [DATA_W-1:0] preset_reg, preset_next;
  logic [DATA_W-1:0] count_reg, count_next;
  logic              flag_reg, flag_next;
  logic [DATA_W-1:0] ctrl_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      en_reg     <= 1'b0;
      mode_reg   <= MODE_ONESHOT;
      im_reg     <= 1'b0;
      preset_reg <= PRESET_RST;
      count_reg  <= '0;
      flag_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      en_reg     <= en_next;
      mode_reg   <= mode_next;
      im_reg     <= im_next;
      preset_reg <= preset_next;
      count_reg  <= count_next;
      flag_reg   <= flag_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    en_next     = en_reg;
    mode_next   = mode_reg;
    im_next     = im_reg;
    preset_next = preset_reg;
    count_next  = count_reg;
    flag_next   = flag_reg;

    case (state_reg)
      S_IDLE: if (en_reg) state_next = S_LOAD;
      S_LOAD: begin
        count_next = preset_reg;
        state_next = S_CNT;
      end
      S_CNT: begin
        if (!en_reg) begin
          state_next = S_IDLE;
        end else if (count_reg > ONE) begin
          count_next = count_reg - ONE;
        end else begin
          count_next = '0;
          state_next = S_INT;
          flag_next  = 1'b1;
        end
      end
      S_INT: begin
        case (mode_reg)
          MODE_RELOAD: begin
            state_next = S_LOAD;
            flag_next  = 1'b0;
          end
          MODE_ONESHOT, 2'b10, 2'b11: begin
            en_next    = 1'b0;
            state_next = S_IDLE;
          end
        endcase
      end
    endcase

    // Bus writes are applied last so they override any FSM update at the same edge.
    if (we) begin
      case (addr)
        TC_CTRL: begin
          en_next   = wdata[CTRL_EN];
          mode_next = wdata[CTRL_MODE_HI:CTRL_MODE_LO];
          im_next   = wdata[CTRL_IM];
          flag_next = 1'b0;
        end
        TC_PRESET: begin
          preset_next = wdata;
          flag_next   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ctrl_word = {{(DATA_W-4){1'b0}}, im_reg, mode_reg, en_reg};

  assign rdata = (addr == TC_CTRL)   ? ctrl_word  :
                 (addr == TC_PRESET) ? preset_reg :
                 (addr == TC_COUNT)  ? count_reg  : '0;

  assign irq = flag_reg & im_reg;

endmodule
